// File: rtl/hazard5_bus_arbiter.sv
// Hazard5 bus arbiter: shares one AHB-Lite master port between
// instruction fetch (I) and load/store (D), D priority with fetch starvation guard.
module hazard5_bus_arbiter #(
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [W_ADDR-1:0] i_addr,
    input  logic              i_addr_vld,
    output logic              i_addr_rdy,
    input  logic              i_size,
    output logic [W_DATA-1:0] i_rdata,
    output logic              i_data_vld,

    input  logic [W_ADDR-1:0] d_addr,
    input  logic              d_addr_vld,
    output logic              d_addr_rdy,
    input  logic [1:0]        d_size,
    input  logic              d_write,
    input  logic [W_DATA-1:0] d_wdata,
    output logic [W_DATA-1:0] d_rdata,
    output logic              d_data_vld,

    output logic [W_ADDR-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [W_DATA-1:0] hwdata,
    input  logic              hready,
    input  logic [W_DATA-1:0] hrdata
);

    typedef enum logic [1:0] {
        M_NONE = 2'd0,
        M_I    = 2'd1,
        M_D    = 2'd2
    } master_t;

    localparam int W_STREAK = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [W_STREAK-1:0] STREAK_MAX = W_STREAK'(STARVE_LIMIT);
    localparam bit GUARD_EN = STARVE_LIMIT != 0;

    master_t             aph_lock;
    master_t             dph_owner;
    master_t             grant;
    logic [W_STREAK-1:0] streak;
    logic [W_DATA-1:0]   hwdata_r;
    logic                unlocked;
    logic                starved;

    assign unlocked = aph_lock == M_NONE;
    assign starved  = GUARD_EN && streak == STREAK_MAX;

    // Grant depends only on requests and registered state, never on hready
    always_comb begin
        grant = M_NONE;
        unique case (1'b1)
            !unlocked:                             grant = aph_lock;
            unlocked && i_addr_vld && !d_addr_vld: grant = M_I;
            unlocked && d_addr_vld && !i_addr_vld: grant = M_D;
            unlocked && i_addr_vld && d_addr_vld:  grant = starved ? M_I : M_D;
            default:                               grant = M_NONE;
        endcase
    end

    always_comb begin
        haddr  = '0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        unique case (grant)
            M_I: begin
                haddr  = i_addr;
                htrans = 2'b10;
                hsize  = i_size ? 3'b010 : 3'b001;
            end
            M_D: begin
                haddr  = d_addr;
                htrans = 2'b10;
                hwrite = d_write;
                hsize  = {1'b0, d_size};
            end
            default: ;
        endcase
    end

    assign i_addr_rdy = hready && grant == M_I;
    assign d_addr_rdy = hready && grant == M_D;

    assign i_data_vld = hready && dph_owner == M_I;
    assign d_data_vld = hready && dph_owner == M_D;
    assign i_rdata    = hrdata;
    assign d_rdata    = hrdata;
    assign hwdata     = hwdata_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aph_lock  <= M_NONE;
            dph_owner <= M_NONE;
            streak    <= '0;
            hwdata_r  <= '0;
        end else begin
            aph_lock <= (grant != M_NONE && !hready) ? grant : M_NONE;
            if (hready) begin
                dph_owner <= grant;
                if (grant == M_D && d_write)
                    hwdata_r <= d_wdata;
            end
            if (!i_addr_vld || i_addr_rdy)
                streak <= '0;
            else if (d_addr_rdy && streak != STREAK_MAX)
                streak <= streak + 1'b1;
        end
    end

endmodule
